// File: rtl/lr35902_intc.sv
// LR35902 interrupt controller: IF/IE registers, fixed-priority source select and CPU vector handshake.
// Optional LR35902_INTC_EDGE_DETECT_EN: treat irq_in as levels and latch IF only on rising edges.
module lr35902_intc #(
  parameter logic [7:0] VEC_BASE = 8'h40,
  parameter logic [7:0] VEC_STEP = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] dout,
  input  logic [7:0] din,
  input  logic       adr,
  input  logic       read,
  input  logic       write,
  input  logic [4:0] irq_in,
  output logic       int_req,
  output logic [7:0] int_vec,
  input  logic       int_ack,
  output logic       wake
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t     r_state;
  logic [4:0] r_if;
  logic [7:0] r_ie;
  logic       r_pwrite;
  logic [7:0] r_dout;
  logic       r_int_req;
  logic [7:0] r_int_vec;
  logic       r_wake;
  logic [2:0] r_ack_idx;

  logic [4:0] w_pending;
  logic [4:0] w_irq_set;
  logic [4:0] w_if_base;
  logic [4:0] w_ack_clr;
  logic [4:0] w_if_next;
  logic [2:0] w_sel;
  logic       w_commit;
  logic       w_ack_take;

  function automatic logic [2:0] f_lowest(input logic [4:0] v);
    f_lowest = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (v[i]) f_lowest = 3'(i);
  endfunction

  function automatic logic [7:0] f_vec(input logic [2:0] idx);
    f_vec = VEC_BASE + 8'(8'(idx) * VEC_STEP);
  endfunction

`ifdef LR35902_INTC_EDGE_DETECT_EN
  logic [4:0] r_irq_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq_prev <= '0;
    else       r_irq_prev <= irq_in;
  end

  assign w_irq_set = irq_in & ~r_irq_prev;
`else
  assign w_irq_set = irq_in;
`endif

  assign w_pending  = r_if & r_ie[4:0];
  assign w_sel      = f_lowest(w_pending);
  assign w_commit   = r_pwrite && !write;
  assign w_ack_take = (r_state == S_REQ) && int_ack && (w_pending != 5'd0);

  // Requests are ORed in last so a same-cycle pulse beats both ack clear and a software write of 0.
  assign w_if_base  = (w_commit && !adr) ? din[4:0] : r_if;
  assign w_ack_clr  = w_ack_take ? (5'd1 << w_sel) : 5'd0;
  assign w_if_next  = (w_if_base & ~w_ack_clr) | w_irq_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if     <= '0;
      r_ie     <= '0;
      r_pwrite <= 1'b0;
      r_dout   <= '0;
      r_wake   <= 1'b0;
    end else begin
      r_pwrite <= write;
      r_if     <= w_if_next;
      if (w_commit && adr) r_ie <= din;
      if (read) r_dout <= adr ? r_ie : {3'b111, r_if};
      r_wake   <= (w_pending != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_int_req <= 1'b0;
      r_int_vec <= VEC_BASE;
      r_ack_idx <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_int_req <= 1'b0;
          if (w_pending != 5'd0) begin
            r_state   <= S_REQ;
            r_int_req <= 1'b1;
            r_int_vec <= f_vec(w_sel);
          end
        end
        S_REQ: begin
          if (w_pending == 5'd0) begin
            r_state   <= S_IDLE;
            r_int_req <= 1'b0;
          end else begin
            // Vector follows the current winner until the CPU commits to it.
            r_int_vec <= f_vec(w_sel);
            if (int_ack) begin
              r_state   <= S_ACK;
              r_int_req <= 1'b0;
              r_ack_idx <= w_sel;
            end
          end
        end
        S_ACK: begin
          r_int_req <= 1'b0;
          r_int_vec <= f_vec(r_ack_idx);
          if (!int_ack) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_int_req <= 1'b0;
        end
      endcase
    end
  end

  assign dout    = r_dout;
  assign int_req = r_int_req;
  assign int_vec = r_int_vec;
  assign wake    = r_wake;

endmodule

// File: tb/tb_lr35902_intc.sv
// Bench for lr35902_intc: directed walk through the handshake cases, then random traffic
// compared cycle-by-cycle against a behavioural model of the interrupt rules.
module tb_lr35902_intc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dout;
  logic [7:0] d;
  logic       a;
  logic       rd;
  logic       wr;
  logic [4:0] irq;
  logic       int_req;
  logic [7:0] int_vec;
  logic       ack;
  logic       wake;

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic       m_pw;
  logic [4:0] m_prev;
  int         m_ph;      // 0 nothing offered, 1 offered to CPU, 2 being serviced
  logic [7:0] e_dout;
  logic       e_req;
  logic [7:0] e_vec;
  logic       e_wake;

  lr35902_intc dut (
    .clk(clk), .reset(rst), .dout(dout), .din(d), .adr(a), .read(rd), .write(wr),
    .irq_in(irq), .int_req(int_req), .int_vec(int_vec), .int_ack(ack), .wake(wake)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_if = '0; m_ie = '0; m_pw = 1'b0; m_prev = '0; m_ph = 0;
    e_dout = 8'h00; e_req = 1'b0; e_vec = 8'h40; e_wake = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] pend, set, nif;
    logic [7:0] nie;
    int sel;
    pend = m_if & m_ie[4:0];
    sel = 0;
    for (int i = 0; i < 5; i++)
      if (pend[i]) begin sel = i; break; end
    set = irq;
`ifdef LR35902_INTC_EDGE_DETECT_EN
    set = irq & ~m_prev;
`endif
    m_prev = irq;
    if (rd) e_dout = a ? m_ie : {3'b111, m_if};
    nif = m_if;
    nie = m_ie;
    if (m_pw && !wr) begin
      if (a) nie = d;
      else   nif = d[4:0];
    end
    if (m_ph == 1 && ack && pend != 0) nif[sel] = 1'b0;
    nif = nif | set;
    e_wake = (pend != 0);
    case (m_ph)
      0: if (pend != 0) begin m_ph = 1; e_req = 1'b1; e_vec = 8'(8'h40 + 8 * sel); end
      1: if (pend == 0) begin
           m_ph = 0; e_req = 1'b0;
         end else begin
           e_vec = 8'(8'h40 + 8 * sel);
           if (ack) begin m_ph = 2; e_req = 1'b0; end
         end
      default: if (!ack) m_ph = 0;
    endcase
    m_if = nif;
    m_ie = nie;
    m_pw = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("dout", dout, e_dout);
    chk("int_req", 8'(int_req), 8'(e_req));
    chk("int_vec", int_vec, e_vec);
    chk("wake", 8'(wake), 8'(e_wake));
  endtask

  task automatic wr_reg(input logic adr_v, input logic [7:0] val);
    wr = 1'b1; a = adr_v; d = val;
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic rd_reg(input logic adr_v);
    rd = 1'b1; a = adr_v;
    tick();
    rd = 1'b0;
  endtask

  task automatic handshake();
    ack = 1'b1; tick();
    ack = 1'b0; tick();
  endtask

  initial begin
    int wphase;
    rst = 1'b1; rd = 0; wr = 0; a = 0; d = 0; irq = 0; ack = 0;
    model_reset();
    #12;
    chk("rst_dout", dout, 8'h00);
    chk("rst_req", 8'(int_req), 8'h00);
    chk("rst_vec", int_vec, 8'h40);
    chk("rst_wake", 8'(wake), 8'h00);
    @(negedge clk); rst = 1'b0;

    rd_reg(1'b0); chk("rd_if_reset", dout, 8'hE0);
    rd_reg(1'b1); chk("rd_ie_reset", dout, 8'h00);

    // timer source, single service
    wr_reg(1'b1, 8'h04);
    irq = 5'h04; tick(); irq = 5'h00;
    rd_reg(1'b0);
    chk("t2_if", dout, 8'hE4);
    chk("t2_req", 8'(int_req), 8'h01);
    chk("t2_vec", int_vec, 8'h50);
    ack = 1'b1; tick();
    chk("t2_req_ack", 8'(int_req), 8'h00);
    rd_reg(1'b0); chk("t2_if_clr", dout, 8'hE0);
    ack = 1'b0; tick();

    // higher priority arrival replaces vector before ack
    wr_reg(1'b1, 8'h1F);
    irq = 5'h10; tick(); irq = 5'h00; tick();
    chk("t3_vec_joy", int_vec, 8'h60);
    irq = 5'h01; tick(); irq = 5'h00; tick();
    chk("t3_vec_vbl", int_vec, 8'h40);
    ack = 1'b1; tick();
    rd_reg(1'b0); chk("t3_if", dout, 8'hF0);
    ack = 1'b0; tick(); tick();
    chk("t3_req_again", 8'(int_req), 8'h01);
    chk("t3_vec_again", int_vec, 8'h60);
    handshake();

    // masked source, then enable via IE
    wr_reg(1'b1, 8'h00);
    irq = 5'h08; tick(); irq = 5'h00; tick(); tick();
    chk("t4_req_masked", 8'(int_req), 8'h00);
    chk("t4_wake_masked", 8'(wake), 8'h00);
    rd_reg(1'b0); chk("t4_if", dout, 8'hE8);
    wr_reg(1'b1, 8'h08);
    tick();
    chk("t4_wake", 8'(wake), 8'h01);
    chk("t4_req", 8'(int_req), 8'h01);
    chk("t4_vec", int_vec, 8'h58);
    handshake();

    // software clear withdraws request; request beats same-cycle write of 0
    wr_reg(1'b1, 8'h04);
    irq = 5'h04; tick(); irq = 5'h00; tick();
    chk("t5_vec", int_vec, 8'h50);
    wr_reg(1'b0, 8'h00);
    tick();
    chk("t5_req_drop", 8'(int_req), 8'h00);
    wr = 1'b1; a = 1'b0; d = 8'h00; tick();
    wr = 1'b0; irq = 5'h04; tick(); irq = 5'h00;
    rd_reg(1'b0); chk("t5_if_race", dout, 8'hE4);
    handshake();

    // held-high STAT source
    wr_reg(1'b1, 8'h02);
    irq = 5'h02;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) ack = 1'b1;
      if (k == 3) ack = 1'b0;
      tick();
    end
    irq = 5'h00;
    rd_reg(1'b0);
`ifdef LR35902_INTC_EDGE_DETECT_EN
    chk("t6_if_held", dout, 8'hE0);
`else
    chk("t6_if_held", dout, 8'hE2);
`endif
    wr_reg(1'b0, 8'h00);

    // random traffic with a CPU that acks the model's offered request
    wphase = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 900) begin
        rst = 1'b1; rd = 0; wr = 0; irq = 0; ack = 0; wphase = 0;
        model_reset();
        #1;
        chk("mid_rst_req", 8'(int_req), 8'h00);
        chk("mid_rst_vec", int_vec, 8'h40);
        @(negedge clk); rst = 1'b0;
      end
      for (int b = 0; b < 5; b++) irq[b] = ($urandom_range(0, 9) == 0);
      if (wphase == 1) begin
        wr = 1'b0; rd = 1'b0; wphase = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        wr = 1'b1; rd = 1'b0; a = 1'($urandom_range(0, 1)); d = 8'($urandom); wphase = 1;
        if (!a && $urandom_range(0, 1) == 1) d = 8'h00;
      end else begin
        rd = ($urandom_range(0, 2) == 0); a = 1'($urandom_range(0, 1));
      end
      if (!ack && e_req && $urandom_range(0, 2) == 0) ack = 1'b1;
      else if (ack && !e_req && $urandom_range(0, 1) == 0) ack = 1'b0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lr35902_intc.md
Name: lr35902_intc

Overview:
Interrupt controller for the LR35902 core. Collects one-cycle request pulses from the timer, LCD (VBlank, STAT), serial and joypad blocks into the IF register, masks them with IE, selects the highest-priority pending source and presents a vector to the CPU. Handshakes the CPU acknowledge and clears the serviced IF bit. Sits on the I/O bus beside the timer (IF at FF0F, IE at FFFF).

Parameters:
VEC_BASE, 8'h40, vector of source 0 (VBlank)
VEC_STEP, 8'h08, vector spacing between consecutive sources

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
dout  out  8  register read data
din  in  8  register write data
adr  in  1  0 = IF (FF0F), 1 = IE (FFFF)
read  in  1  read strobe
write  in  1  write strobe; commits on falling edge
irq_in  in  5  bit0 VBlank, 1 STAT, 2 timer, 3 serial, 4 joypad; one-clk pulses
int_req  out  1  enabled interrupt pending, offered to CPU
int_vec  out  8  vector of offered source
int_ack  in  1  CPU acknowledge, level, held until int_req falls
wake  out  1  |(IF & IE & 5'h1f), for HALT/STOP exit, independent of IME

Behaviour:
- Reset (async): IF=0, IE=0, pwrite=0, dout=0, FSM=IDLE, int_req=0, int_vec=VEC_BASE, wake=0.
- Reads: when read=1 at clk edge, dout <= adr ? IE : {3'b111, IF[4:0]}. One clk latency; dout holds between reads.
- Writes: pwrite <= write each clk. pwrite && !write commits din to IF[4:0] (adr 0) or IE[7:0] (adr 1). IE bits 7:5 are stored and read back but never enable anything.
- IF update per clk, in priority order: base = IF (or din on IF write commit); clear the acked bit; then OR irq_in. A request wins over a same-cycle ack clear or software write of 0.
- pending = IF & IE[4:0]; sel = lowest set index of pending (bit0 highest priority).
- FSM:
  - IDLE: int_req=0. pending!=0 -> REQ.
  - REQ: int_req=1. int_vec = VEC_BASE + sel*VEC_STEP, tracked each clk so a higher-priority arrival replaces the vector before ack. pending goes to 0 (software clear or IE change) -> IDLE, int_req drops next clk. int_ack=1 -> latch ack_idx=sel, clear IF[ack_idx] that clk, -> ACK.
  - ACK: int_req=0. int_vec frozen at the acked vector. Stays until int_ack=0, then -> IDLE. The next request is re-evaluated from IDLE, giving at least one idle clk between services.
- int_req, int_vec and wake are registered outputs, updated one clk after the causing event.
- int_ack seen in IDLE is ignored (no IF change).
- wake is valid in any FSM state.
- Reset asserted mid-handshake returns to IDLE immediately; IF is lost.

Optional Feature:
LR35902_INTC_EDGE_DETECT_EN
- Defined: irq_in bits are level inputs. The block keeps a registered copy (cleared on reset) and sets IF only on a 0->1 transition. A held-high source sets IF once.
- Undefined: irq_in bits are treated as pulses; every clk a bit is high it ORs into IF. No edge registers are built.

Test Plan:
- Reset, then read adr0 and adr1 -> dout 8'hE0, then 8'h00. int_req=0, wake=0.
- IE=8'h04, pulse irq_in[2] for 1 clk -> IF reads 8'hE4. int_req=1, int_vec=8'h50 next clk. Assert int_ack -> IF reads 8'hE0, int_req=0. Drop ack -> FSM IDLE.
- IE=8'h1F, pulse irq_in[4], then irq_in[0] 2 clks later before ack -> int_vec goes 8'h60, then 8'h40. Ack clears only bit0 and IF=8'hF0. After ack drops, int_req reasserts with int_vec=8'h60.
- IE=0, pulse irq_in[3] -> int_req stays 0, wake=0, IF=8'hE8. Write IE=8'h08 -> wake=1, int_req=1, int_vec=8'h58.
- In REQ with vector 8'h50, write IF=0 -> int_req drops, FSM IDLE. Same-clk IF write 0 and irq_in[2] pulse -> IF bit2 stays set.
- With LR35902_INTC_EDGE_DETECT_EN, hold irq_in[1] high 10 clks, ack once -> IF bit1 stays 0 afterward and the source is serviced once. Without the macro, the bit is re-set every clk.
